// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: default field widths, the bubble instruction and the occupancy-width helper.
// Reused by every stage register so a bubble means the same encoding everywhere.
package pipeline_pkg;

  localparam int PC_W_DEF    = 32;
  localparam int INSTR_W_DEF = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-side push handshake, decode-side head view, stall and flush for the IF/ID queue.
// The slave modport is the queue; the master modport is the fetch/decode side driving it.
interface if_id_queue_if
  import pipeline_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH   = 4
);

  logic                      flush;
  logic                      if_valid;
  logic                      if_ready;
  logic [PC_W-1:0]           if_pc_4;
  logic [INSTR_W-1:0]        if_instruction;
  logic                      id_stall;
  logic                      id_valid;
  logic [PC_W-1:0]           id_pc_4;
  logic [INSTR_W-1:0]        id_instruction;
  logic [cnt_w(DEPTH)-1:0]   count;

  modport slave (
    input  flush, if_valid, if_pc_4, if_instruction, id_stall,
    output if_ready, id_valid, id_pc_4, id_instruction, count
  );

  modport master (
    output flush, if_valid, if_pc_4, if_instruction, id_stall,
    input  if_ready, id_valid, id_pc_4, id_instruction, count
  );

endinterface

// File: rtl/if_id_queue.sv
// In-order DEPTH-entry queue of (pc+4, instruction) between fetch and decode; pushes appear on id_* one edge later.
// Fetch is backpressured only when full (no pop-bypass); decode stall holds the head; flush empties the queue.
module if_id_queue
  import pipeline_pkg::*;
#(
  parameter int                 PC_W    = PC_W_DEF,
  parameter int                 INSTR_W = INSTR_W_DEF,
  parameter int                 DEPTH   = 4,
  parameter logic [INSTR_W-1:0] NOP     = INSTR_W'(NOP_INSTR)
) (
  input  logic            clk,
  input  logic            rst,
  if_id_queue_if.slave    bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PC_W-1:0]    last_pc_4_q, last_pc_4_d;
  logic [PC_W-1:0]    pc_mem_q    [DEPTH];
  logic [PC_W-1:0]    pc_mem_d    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [INSTR_W-1:0] instr_mem_d [DEPTH];

  logic full, empty, push, pop;

  // Status derives from registered count only, so no input reaches an output combinationally.
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.if_valid & ~full & ~bus.flush;
  assign pop   = ~empty & ~bus.id_stall & ~bus.flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    last_pc_4_d = last_pc_4_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;

    if (push) begin
      pc_mem_d[wr_ptr_q]    = bus.if_pc_4;
      instr_mem_d[wr_ptr_q] = bus.if_instruction;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      last_pc_4_d = pc_mem_q[rd_ptr_q];
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // A redirect drops everything in flight but keeps the last value decode saw.
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_pc_4_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      last_pc_4_q <= last_pc_4_d;
    end
  end

  // Storage is never visible while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    pc_mem_q    <= pc_mem_d;
    instr_mem_q <= instr_mem_d;
  end

  assign bus.if_ready       = ~full;
  assign bus.id_valid       = ~empty;
  assign bus.id_pc_4        = empty ? last_pc_4_q : pc_mem_q[rd_ptr_q];
  assign bus.id_instruction = empty ? NOP : instr_mem_q[rd_ptr_q];
  assign bus.count          = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_if_id_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_id_queue_if #(.PC_W(32), .INSTR_W(32), .DEPTH(DEPTH)) bus ();

  if_id_queue #(.PC_W(32), .INSTR_W(32), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ent_t        mq[$];
  logic [31:0] m_last;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [2:0] e_cnt();
    return 3'(mq.size());
  endfunction
  function automatic logic e_vld();
    return mq.size() != 0;
  endfunction
  function automatic logic [31:0] e_pc();
    return (mq.size() != 0) ? mq[0].pc : m_last;
  endfunction
  function automatic logic [31:0] e_ins();
    return (mq.size() != 0) ? mq[0].ins : 32'h0;
  endfunction
  function automatic logic e_rdy();
    return mq.size() != DEPTH;
  endfunction

  // Drive one cycle of inputs, advance the model by the same edge, then settle past the edge.
  task automatic cycle(input logic r, input logic fl, input logic v, input logic st,
                       input logic [31:0] pc, input logic [31:0] ins);
    logic push_ok, pop_ok;
    rst                = r;
    bus.flush          = fl;
    bus.if_valid       = v;
    bus.id_stall       = st;
    bus.if_pc_4        = pc;
    bus.if_instruction = ins;
    @(posedge clk);
    if (!r) begin
      mq.delete();
      m_last = 32'h0;
    end else if (fl) begin
      mq.delete();
    end else begin
      push_ok = v && (mq.size() < DEPTH);
      pop_ok  = (mq.size() != 0) && !st;
      if (pop_ok) begin
        m_last = mq[0].pc;
        void'(mq.pop_front());
      end
      if (push_ok) mq.push_back('{pc: pc, ins: ins});
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h99, 32'h1234);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h9c, 32'h5678);
    n_tests++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    n_tests++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid got=%b exp=0", bus.id_valid); end
    n_tests++; if (bus.id_instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h exp=0", bus.id_instruction); end
    n_tests++; if (bus.id_pc_4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", bus.id_pc_4); end
    n_tests++; if (bus.if_ready !== 1'b1) begin n_fail++; $display("FAIL reset_if_ready got=%b exp=1", bus.if_ready); end
  endtask

  task automatic test_pass_through();
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h4, 32'h2008_0001);
    n_tests++; if (bus.id_valid !== 1'b1) begin n_fail++; $display("FAIL pt_valid got=%b exp=1", bus.id_valid); end
    n_tests++; if (bus.id_pc_4 !== 32'h4) begin n_fail++; $display("FAIL pt_pc got=%h exp=4", bus.id_pc_4); end
    n_tests++; if (bus.id_instruction !== 32'h2008_0001) begin n_fail++; $display("FAIL pt_instr got=%h exp=20080001", bus.id_instruction); end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_tests++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL pt_popped_valid got=%b exp=0", bus.id_valid); end
    n_tests++; if (bus.id_pc_4 !== 32'h4) begin n_fail++; $display("FAIL pt_hold_pc got=%h exp=4", bus.id_pc_4); end
    n_tests++; if (bus.id_instruction !== 32'h0) begin n_fail++; $display("FAIL pt_nop got=%h exp=0", bus.id_instruction); end
  endtask

  task automatic test_stall_fill();
    for (int i = 1; i <= 4; i++)
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'(4 * i), 32'hA000_0000 + 32'(i));
    n_tests++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL fill_count got=%0d exp=4", bus.count); end
    n_tests++; if (bus.if_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready got=%b exp=0", bus.if_ready); end
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h14, 32'hDEAD_BEEF);
    n_tests++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL fill_fifth_count got=%0d exp=4", bus.count); end
    for (int i = 1; i <= 4; i++) begin
      n_tests++;
      if (bus.id_pc_4 !== 32'(4 * i) || bus.id_instruction !== 32'hA000_0000 + 32'(i)) begin
        n_fail++;
        $display("FAIL drain_%0d got=%h/%h exp=%h/%h", i, bus.id_pc_4, bus.id_instruction, 32'(4 * i), 32'hA000_0000 + 32'(i));
      end
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    n_tests++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got=%b exp=0", bus.id_valid); end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h40 + 32'(4 * i), 32'hB000_0000 + 32'(i));
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'hC000_0000);
    n_tests++; if (bus.count !== 3'd3) begin n_fail++; $display("FAIL fullpop_count got=%0d exp=3", bus.count); end
    n_tests++; if (bus.id_pc_4 !== 32'h44) begin n_fail++; $display("FAIL fullpop_head got=%h exp=44", bus.id_pc_4); end
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h104, 32'hC000_0001);
    n_tests++; if (bus.count !== 3'd3) begin n_fail++; $display("FAIL pushpop_count got=%0d exp=3", bus.count); end
    n_tests++; if (bus.id_pc_4 !== 32'h48) begin n_fail++; $display("FAIL pushpop_head got=%h exp=48", bus.id_pc_4); end
  endtask

  task automatic test_flush();
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'hF1F1_F1F1);
    n_tests++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL flush_count got=%0d exp=0", bus.count); end
    n_tests++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", bus.id_valid); end
    n_tests++; if (bus.id_instruction !== 32'h0) begin n_fail++; $display("FAIL flush_instr got=%h exp=0", bus.id_instruction); end
    n_tests++; if (bus.id_pc_4 !== 32'h44) begin n_fail++; $display("FAIL flush_last_pc got=%h exp=44", bus.id_pc_4); end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_tests++; if (bus.id_valid !== 1'b0 || bus.id_pc_4 === 32'h200) begin n_fail++; $display("FAIL flush_dropped got=%b/%h exp=0/44", bus.id_valid, bus.id_pc_4); end
  endtask

  task automatic test_wrap();
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h4, 32'hE000_0001);
    for (int i = 2; i <= 10; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'(4 * i), 32'hE000_0000 + 32'(i));
      n_tests++;
      if (bus.id_pc_4 !== 32'(4 * i) || bus.count !== 3'd1 || bus.id_instruction !== 32'hE000_0000 + 32'(i)) begin
        n_fail++;
        $display("FAIL wrap_%0d got pc=%h cnt=%0d exp pc=%h cnt=1", i, bus.id_pc_4, bus.count, 32'(4 * i));
      end
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_tests++; if (bus.id_valid !== 1'b0 || bus.id_pc_4 !== 32'h28) begin n_fail++; $display("FAIL wrap_end got=%b/%h exp=0/28", bus.id_valid, bus.id_pc_4); end
  endtask

  task automatic test_random();
    logic r, fl, v, st;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 63) != 0);
      fl = ($urandom_range(0, 15) == 0);
      v  = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 2) == 0);
      cycle(r, fl, v, st, $urandom, $urandom);
      n_tests++;
      if (bus.count !== e_cnt() || bus.id_valid !== e_vld() || bus.if_ready !== e_rdy() ||
          bus.id_pc_4 !== e_pc() || bus.id_instruction !== e_ins()) begin
        n_fail++;
        $display("FAIL rand_%0d got cnt=%0d v=%b rdy=%b pc=%h ins=%h exp cnt=%0d v=%b rdy=%b pc=%h ins=%h",
                 i, bus.count, bus.id_valid, bus.if_ready, bus.id_pc_4, bus.id_instruction,
                 e_cnt(), e_vld(), e_rdy(), e_pc(), e_ins());
      end
    end
  endtask

  initial begin
    m_last             = 32'h0;
    rst                = 1'b0;
    bus.flush          = 1'b0;
    bus.if_valid       = 1'b0;
    bus.id_stall       = 1'b0;
    bus.if_pc_4        = 32'h0;
    bus.if_instruction = 32'h0;
    #1;
    test_reset();
    test_pass_through();
    test_stall_fill();
    test_full_pop();
    test_flush();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
